// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor controller.
package sub_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requester and the serial subtractor controller.
interface serial_sub_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/full_sub_cell.sv
// Combinational one-bit full subtractor: D = A - B - Bin, Bout set on underflow.
module full_sub_cell (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);
  logic a_xor_b;

  assign a_xor_b = A ^ B;
  assign D       = a_xor_b ^ Bin;
  assign Bout    = (~A & B) | (~a_xor_b & Bin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: sequences one full_sub_cell LSB first, one bit per clock.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_sub_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;

  logic             cell_d, cell_bout;
  logic             last_bit;
  logic [WIDTH-1:0] res_shift;

  full_sub_cell u_cell (
    .A    (a_sr_q[0]),
    .B    (b_sr_q[0]),
    .Bin  (borrow_q),
    .D    (cell_d),
    .Bout (cell_bout)
  );

  assign last_bit  = (cnt_q == CntW'(WIDTH - 1));
  // New bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  assign res_shift = (res_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StRun;
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          borrow_d = bus.borrow_in;
          cnt_d    = '0;
          res_d    = '0;
        end
      end
      StRun: begin
        res_d    = res_shift;
        borrow_d = cell_bout;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (last_bit) begin
          state_d = StDone;
          diff_d  = res_shift;
          bout_d  = cell_bout;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;

endmodule
